// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out frame controller:
// FSM state encoding and bit-counter width helper.
package sipo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter must hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Left shift register with enable and synchronous clear; serial bit enters bit 0.
// A clear with enable set loads the incoming bit as the first bit of a fresh word.
module sipo_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift path: clear has priority, then an optional fresh first bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= i_en ? {{(WIDTH-1){1'b0}}, i_bit} : '0;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], i_bit};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_controller.sv
// Frame controller: counts OUTPUT_WIDTH qualified serial bits per frame and
// commits each word to a holding register offered over valid/ready.
module sipo_frame_controller
  import sipo_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 8,
  parameter int CONTINUOUS   = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic                    bit_valid,
  input  logic                    serial_in,
  input  logic                    data_ready,
  input  logic                    overflow_clear,
  output logic [OUTPUT_WIDTH-1:0] data,
  output logic                    data_valid,
  output logic                    busy,
  output logic                    frame_abort,
  output logic                    overflow
);

  localparam int CW = cnt_width(OUTPUT_WIDTH);

  logic                    r_rst_meta;
  logic                    r_rst_sync;
  state_e                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_busy;
  logic                    r_abort;
  logic [OUTPUT_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_ovf;

  logic                    w_rst_n;
  logic                    w_last;
  logic                    w_complete;
  logic                    w_shift_en;
  logic                    w_shift_clr;
  logic                    w_commit;
  logic                    w_drop;
  logic [OUTPUT_WIDTH-1:0] w_shift_q;
  logic [OUTPUT_WIDTH-1:0] w_word;

  // Reset synchroniser: assert immediately, release after two edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n     = r_rst_sync;
  assign w_last      = (r_cnt == CW'(OUTPUT_WIDTH - 1));
  assign w_complete  = (r_state == ST_SHIFT) && !frame_start && bit_valid && w_last;
  assign w_shift_en  = bit_valid && (frame_start || (r_state == ST_SHIFT)) && !w_complete;
  assign w_shift_clr = frame_start || w_complete;
  // The completing bit is never stored; the committed word is assembled on the fly.
  assign w_word      = {w_shift_q[OUTPUT_WIDTH-2:0], serial_in};
  assign w_commit    = w_complete && (!r_valid || data_ready);
  assign w_drop      = w_complete && r_valid && !data_ready;

  sipo_shift_core #(
    .WIDTH (OUTPUT_WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (w_rst_n),
    .i_clr (w_shift_clr),
    .i_en  (w_shift_en),
    .i_bit (serial_in),
    .o_q   (w_shift_q)
  );

  // Frame FSM, bit counter, busy and abort pulse.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_cnt   <= bit_valid ? CW'(1) : '0;
          end
        end
        ST_SHIFT: begin
          if (frame_start) begin
            r_abort <= (r_cnt != '0);
            r_cnt   <= bit_valid ? CW'(1) : '0;
          end else if (bit_valid) begin
            if (w_last) begin
              r_cnt <= '0;
              if (CONTINUOUS == 0) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register, valid/ready handshake and sticky overflow.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (overflow_clear) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign busy        = r_busy;
  assign frame_abort = r_abort;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Self-checking bench: table-driven frames, scoreboard on accepted words,
// hand-written sequences for overflow, replace, abort, continuous mode and reset.
module tb_sipo_frame_controller;

  logic       clk = 1'b0;
  logic       reset_n, fs0, fs1, bit_valid, serial_in, data_ready, overflow_clear;
  logic [7:0] d0, d1;
  logic       v0, b0, a0, o0, v1, b1, a1, o1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tgt1 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int t1[3];
  int n1 = 0;
  logic [7:0] e0, e1;

  typedef struct {
    logic [7:0] word;
    int         gap;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sipo_frame_controller #(.OUTPUT_WIDTH(8), .CONTINUOUS(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .frame_start(fs0), .bit_valid(bit_valid),
    .serial_in(serial_in), .data_ready(data_ready), .overflow_clear(overflow_clear),
    .data(d0), .data_valid(v0), .busy(b0), .frame_abort(a0), .overflow(o0));

  sipo_frame_controller #(.OUTPUT_WIDTH(8), .CONTINUOUS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .frame_start(fs1), .bit_valid(bit_valid),
    .serial_in(serial_in), .data_ready(data_ready), .overflow_clear(overflow_clear),
    .data(d1), .data_valid(v1), .busy(b1), .frame_abort(a1), .overflow(o1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive bits w[hi..lo]; gap idle cycles precede every bit except a frame-start bit.
  task automatic send_bits(input logic [7:0] w, input int hi, input int lo,
                           input bit start, input int gap);
    for (int i = hi; i >= lo; i--) begin
      if (!(start && i == hi)) repeat (gap) tick();
      if (start && i == hi) begin
        if (tgt1) fs1 = 1'b1;
        else fs0 = 1'b1;
      end
      bit_valid = 1'b1;
      serial_in = w[i];
      tick();
      fs0 = 1'b0;
      fs1 = 1'b0;
      bit_valid = 1'b0;
    end
  endtask

  // Scoreboard for the CONTINUOUS=0 instance.
  always @(negedge clk) begin
    if (v0 && data_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected: got %0h expected none", d0);
      end else begin
        e0 = q0.pop_front();
        chk("sb0_data", {24'h0, d0}, {24'h0, e0});
      end
    end
  end

  // Scoreboard for the CONTINUOUS=1 instance, recording accept cycles.
  always @(negedge clk) begin
    if (v1 && data_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got %0h expected none", d1);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_data", {24'h0, d1}, {24'h0, e1});
        if (n1 < 3) t1[n1] = cyc;
        n1++;
      end
    end
  end

  initial begin
    vecs[0] = '{word: 8'hB2, gap: 0, exp: 8'hB2};
    vecs[1] = '{word: 8'h5A, gap: 2, exp: 8'h5A};
    vecs[2] = '{word: 8'hFF, gap: 0, exp: 8'hFF};
    vecs[3] = '{word: 8'h00, gap: 1, exp: 8'h00};
    vecs[4] = '{word: 8'h81, gap: 0, exp: 8'h81};

    reset_n = 1'b0; fs0 = 1'b0; fs1 = 1'b0; bit_valid = 1'b0;
    serial_in = 1'b0; data_ready = 1'b1; overflow_clear = 1'b0;
    repeat (3) tick();
    chk("rst_data", {24'h0, d0}, 32'h0);
    chk("rst_valid", {31'h0, v0}, 32'h0);
    chk("rst_busy", {31'h0, b0}, 32'h0);
    chk("rst_abort", {31'h0, a0}, 32'h0);
    chk("rst_ovf", {31'h0, o0}, 32'h0);
    reset_n = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < 5; k++) begin
      q0.push_back(vecs[k].exp);
      send_bits(vecs[k].word, 7, 1, 1'b1, vecs[k].gap);
      chk("vec_valid_early", {31'h0, v0}, 32'h0);
      chk("vec_busy_mid", {31'h0, b0}, 32'h1);
      send_bits(vecs[k].word, 0, 0, 1'b0, vecs[k].gap);
      chk("vec_valid", {31'h0, v0}, 32'h1);
      chk("vec_data", {24'h0, d0}, {24'h0, vecs[k].exp});
      chk("vec_busy_after", {31'h0, b0}, 32'h0);
      chk("vec_abort", {31'h0, a0}, 32'h0);
      tick();
      chk("vec_valid_1cyc", {31'h0, v0}, 32'h0);
    end

    // Overflow with ready low; clear asserted during the drop loses to the set.
    data_ready = 1'b0;
    q0.push_back(8'h11);
    send_bits(8'h11, 7, 0, 1'b1, 0);
    chk("ovf_first_valid", {31'h0, v0}, 32'h1);
    overflow_clear = 1'b1;
    send_bits(8'h22, 7, 0, 1'b1, 0);
    chk("ovf_data_held", {24'h0, d0}, 32'h11);
    chk("ovf_set_wins", {31'h0, o0}, 32'h1);
    tick();
    overflow_clear = 1'b0;
    chk("ovf_cleared", {31'h0, o0}, 32'h0);
    chk("ovf_still_valid", {31'h0, v0}, 32'h1);
    data_ready = 1'b1;
    tick();
    chk("ovf_valid_drop", {31'h0, v0}, 32'h0);

    // Same-cycle replace.
    data_ready = 1'b0;
    q0.push_back(8'h33);
    send_bits(8'h33, 7, 0, 1'b1, 0);
    q0.push_back(8'h44);
    send_bits(8'h44, 7, 1, 1'b1, 0);
    chk("rep_hold", {24'h0, d0}, 32'h33);
    data_ready = 1'b1;
    send_bits(8'h44, 0, 0, 1'b0, 0);
    chk("rep_data", {24'h0, d0}, 32'h44);
    chk("rep_valid", {31'h0, v0}, 32'h1);
    chk("rep_ovf", {31'h0, o0}, 32'h0);
    tick();
    chk("rep_valid_drop", {31'h0, v0}, 32'h0);

    // Resync after 5 bits.
    q0.push_back(8'hC3);
    send_bits(8'hF0, 7, 3, 1'b1, 0);
    chk("abt_pre", {31'h0, a0}, 32'h0);
    send_bits(8'hC3, 7, 7, 1'b1, 0);
    chk("abt_pulse", {31'h0, a0}, 32'h1);
    send_bits(8'hC3, 6, 6, 1'b0, 0);
    chk("abt_one_cycle", {31'h0, a0}, 32'h0);
    send_bits(8'hC3, 5, 0, 1'b0, 0);
    chk("abt_data", {24'h0, d0}, 32'hC3);
    chk("abt_valid", {31'h0, v0}, 32'h1);
    tick();

    // frame_start in SHIFT with zero bits counted: no abort.
    fs0 = 1'b1;
    tick();
    fs0 = 1'b0;
    chk("noabt_busy", {31'h0, b0}, 32'h1);
    q0.push_back(8'h5C);
    send_bits(8'h5C, 7, 7, 1'b1, 0);
    chk("noabt_pulse", {31'h0, a0}, 32'h0);
    send_bits(8'h5C, 6, 0, 1'b0, 0);
    chk("noabt_data", {24'h0, d0}, 32'h5C);
    tick();

    // Continuous mode: one frame_start, 24 contiguous bits.
    tgt1 = 1'b1;
    q1.push_back(8'hA1);
    q1.push_back(8'hB2);
    q1.push_back(8'hC3);
    send_bits(8'hA1, 7, 0, 1'b1, 0);
    send_bits(8'hB2, 7, 0, 1'b0, 0);
    send_bits(8'hC3, 7, 0, 1'b0, 0);
    chk("cont_busy", {31'h0, b1}, 32'h1);
    chk("cont_valid", {31'h0, v1}, 32'h1);
    tick();
    chk("cont_commits", n1, 32'd3);
    if (n1 >= 3) begin
      chk("cont_gap01", t1[1] - t1[0], 32'd8);
      chk("cont_gap12", t1[2] - t1[1], 32'd8);
    end
    chk("cont_data_held", {24'h0, d1}, 32'hC3);
    chk("cont_idle0", {31'h0, b0}, 32'h0);

    // Asynchronous reset mid-frame.
    send_bits(8'h96, 7, 4, 1'b0, 0);
    chk("mid_busy", {31'h0, b1}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'h0, d1}, 32'h0);
    chk("mid_rst_valid", {31'h0, v1}, 32'h0);
    chk("mid_rst_busy", {31'h0, b1}, 32'h0);
    chk("mid_rst_abort", {31'h0, a1}, 32'h0);
    chk("mid_rst_ovf", {31'h0, o1}, 32'h0);
    chk("mid_rst_data0", {24'h0, d0}, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send_bits(8'hFF, 7, 0, 1'b0, 0);
    tick();
    chk("post_rst_idle", {31'h0, b1}, 32'h0);
    chk("post_rst_novalid", {31'h0, v1}, 32'h0);
    chk("post_rst_abort", {31'h0, a1}, 32'h0);

    chk("sb0_empty", q0.size(), 32'd0);
    chk("sb1_empty", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
